// File: rtl/axil_reg_responder.sv
// AXI4-Lite slave register bank (NUM_REGS x 32-bit) with OKAY/SLVERR responses.
// Ports:
//   axi_clk, axi_reset_n        clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*             write address / data / response channels
//   s_axi_ar*/r*                read address / data channels
//   reg_wr_pulse, reg_wr_index  one-cycle strobe + index of a committed legal write
//   snap_index, snap_data       combinational register observation port
module axil_reg_responder #(
  parameter int unsigned ADDR_WIDTH  = 11,
  parameter int unsigned NUM_REGS    = 64,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic                        axi_clk,
  input  logic                        axi_reset_n,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [ADDR_WIDTH-1:0]       s_axi_awaddr,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  input  logic [31:0]                 s_axi_wdata,
  input  logic [3:0]                  s_axi_wstrb,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  output logic [1:0]                  s_axi_bresp,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  input  logic [ADDR_WIDTH-1:0]       s_axi_araddr,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready,
  output logic [31:0]                 s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        reg_wr_pulse,
  output logic [$clog2(NUM_REGS)-1:0] reg_wr_index,
  input  logic [$clog2(NUM_REGS)-1:0] snap_index,
  output logic [31:0]                 snap_data
);

  localparam int unsigned IDX_W       = $clog2(NUM_REGS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;

  logic [31:0] regs [NUM_REGS];

  // ---------------- write path ----------------
  wstate_t               wstate_q, wstate_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [31:0]           w_data_q;
  logic [3:0]            w_strb_q;
  logic                  latch_aw, latch_w, commit;
  logic                  aw_hs, w_hs;
  logic                  wr_pulse_q;
  logic [IDX_W-1:0]      wr_index_q;

  logic [ADDR_WIDTH-1:0] cmt_addr;
  logic [31:0]           cmt_data;
  logic [3:0]            cmt_strb;
  logic [IDX_W-1:0]      cmt_idx;
  logic                  cmt_in_range;
  logic                  wr_en;

  assign aw_hs = s_axi_awvalid && awready_q;
  assign w_hs  = s_axi_wvalid && wready_q;

  // Whichever half arrived earlier comes from its holding register, the other live.
  assign cmt_addr     = (wstate_q == W_HAVE_AW) ? aw_addr_q : s_axi_awaddr;
  assign cmt_data     = (wstate_q == W_HAVE_W)  ? w_data_q  : s_axi_wdata;
  assign cmt_strb     = (wstate_q == W_HAVE_W)  ? w_strb_q  : s_axi_wstrb;
  assign cmt_idx      = cmt_addr[IDX_W+1:2];
  assign cmt_in_range = 32'(cmt_addr[ADDR_WIDTH-1:2]) < NUM_REGS;
  assign wr_en        = commit && cmt_in_range;

  always_comb begin
    wstate_d  = wstate_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    latch_aw  = 1'b0;
    latch_w   = 1'b0;
    commit    = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
        end else if (aw_hs) begin
          latch_aw  = 1'b1;
          awready_d = 1'b0;
          wstate_d  = W_HAVE_AW;
        end else if (w_hs) begin
          latch_w  = 1'b1;
          wready_d = 1'b0;
          wstate_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: if (w_hs) commit = 1'b1;
      W_HAVE_W:  if (aw_hs) commit = 1'b1;
      W_RESP: begin
        if (s_axi_bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
    if (commit) begin
      wstate_d  = W_RESP;
      awready_d = 1'b0;
      wready_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = cmt_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      wstate_q   <= W_IDLE;
      awready_q  <= 1'b1;
      wready_q   <= 1'b1;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      wr_pulse_q <= 1'b0;
      wr_index_q <= '0;
    end else begin
      wstate_q   <= wstate_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_en;
      if (latch_aw) aw_addr_q <= s_axi_awaddr;
      if (latch_w) begin
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      if (wr_en) wr_index_q <= cmt_idx;
    end
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
    end else if (wr_en) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (cmt_strb[k]) regs[cmt_idx][8*k +: 8] <= cmt_data[8*k +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  rstate_t          rstate_q, rstate_d;
  logic             arready_q, arready_d;
  logic             rvalid_q, rvalid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [1:0]       rresp_q, rresp_d;
  logic             ar_hs;
  logic             ar_in_range;
  logic [IDX_W-1:0] ar_idx;

  assign ar_hs       = s_axi_arvalid && arready_q;
  assign ar_idx      = s_axi_araddr[IDX_W+1:2];
  assign ar_in_range = 32'(s_axi_araddr[ADDR_WIDTH-1:2]) < NUM_REGS;

  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (ar_hs) begin
          rstate_d  = R_RESP;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          // Bank sampled before this edge's write lands: same-cycle read sees old data.
          rdata_d   = ar_in_range ? regs[ar_idx] : '0;
          rresp_d   = ar_in_range ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_RESP: begin
        if (s_axi_rready) begin
          rstate_d  = R_IDLE;
          arready_d = 1'b1;
          rvalid_d  = 1'b0;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // ---------------- observation ----------------
  always_comb begin
    snap_data = '0;
    if (32'(snap_index) < NUM_REGS) snap_data = regs[snap_index];
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{cmt_addr[1:0], s_axi_araddr[1:0]};

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign reg_wr_pulse  = wr_pulse_q;
  assign reg_wr_index  = wr_index_q;

endmodule

// File: tb/tb_axil_reg_responder.sv
module tb_axil_reg_responder;

  logic        axi_clk = 1'b0;
  logic        axi_reset_n;
  logic        s_axi_awvalid, s_axi_awready;
  logic [10:0] s_axi_awaddr;
  logic        s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_bvalid, s_axi_bready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arvalid, s_axi_arready;
  logic [10:0] s_axi_araddr;
  logic        s_axi_rvalid, s_axi_rready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        reg_wr_pulse;
  logic [5:0]  reg_wr_index;
  logic [5:0]  snap_index;
  logic [31:0] snap_data;

  axil_reg_responder #(
    .ADDR_WIDTH (11),
    .NUM_REGS   (64),
    .RESET_VALUE(32'h0000_0000)
  ) dut (
    .axi_clk      (axi_clk),
    .axi_reset_n  (axi_reset_n),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wstrb  (s_axi_wstrb),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_araddr (s_axi_araddr),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp),
    .reg_wr_pulse (reg_wr_pulse),
    .reg_wr_index (reg_wr_index),
    .snap_index   (snap_index),
    .snap_data    (snap_data)
  );

  always #5 axi_clk = ~axi_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int pulse_cnt = 0;

  always @(posedge axi_clk) if (reg_wr_pulse === 1'b1) pulse_cnt++;

  typedef struct {
    logic        wr;
    logic [10:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [1:0]  resp;
    logic [31:0] data;
    logic        pulse;
    logic [5:0]  idx;
  } exp_t;

  vec_t vecs[14];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic drive_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] resp);
    int n;
    logic aw_done, w_done, aw_hs, w_hs;
    exp_t e;
    e.wr = 1'b1; e.resp = resp; e.data = '0;
    e.pulse = (resp == 2'b00); e.idx = a[7:2];
    sb.push_back(e);
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      tick();
      if (aw_hs) begin aw_done = 1'b1; s_axi_awvalid = 1'b0; end
      if (w_hs)  begin w_done  = 1'b1; s_axi_wvalid  = 1'b0; end
      n++;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    if (!(aw_done && w_done)) check("write handshake timeout", 32'd0, 32'd1);
  endtask

  task automatic collect_write();
    int n;
    exp_t e;
    check("bvalid latency", 32'(s_axi_bvalid), 32'd1);
    n = 0;
    while (s_axi_bvalid !== 1'b1 && n < 20) begin tick(); n++; end
    if (s_axi_bvalid !== 1'b1) check("bvalid timeout", 32'd0, 32'd1);
    if (sb.size() == 0) begin
      check("scoreboard empty on B", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("entry kind on B", 32'(e.wr), 32'd1);
      check("bresp", 32'(s_axi_bresp), 32'(e.resp));
      check("reg_wr_pulse", 32'(reg_wr_pulse), 32'(e.pulse));
      if (e.pulse) check("reg_wr_index", 32'(reg_wr_index), 32'(e.idx));
    end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    check("pulse single cycle", 32'(reg_wr_pulse), 32'd0);
    check("bvalid after B hs", 32'(s_axi_bvalid), 32'd0);
    check("awready after B hs", 32'(s_axi_awready), 32'd1);
  endtask

  task automatic drive_read(input logic [10:0] a, input logic [1:0] resp, input logic [31:0] d);
    int n;
    logic done, hs;
    exp_t e;
    e.wr = 1'b0; e.resp = resp; e.data = d; e.pulse = 1'b0; e.idx = '0;
    sb.push_back(e);
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    done = 1'b0; n = 0;
    while (!done && n < 20) begin
      hs = s_axi_arvalid && s_axi_arready;
      tick();
      if (hs) begin done = 1'b1; s_axi_arvalid = 1'b0; end
      n++;
    end
    s_axi_arvalid = 1'b0;
    if (!done) check("read handshake timeout", 32'd0, 32'd1);
  endtask

  task automatic collect_read();
    int n;
    exp_t e;
    check("rvalid latency", 32'(s_axi_rvalid), 32'd1);
    n = 0;
    while (s_axi_rvalid !== 1'b1 && n < 20) begin tick(); n++; end
    if (s_axi_rvalid !== 1'b1) check("rvalid timeout", 32'd0, 32'd1);
    if (sb.size() == 0) begin
      check("scoreboard empty on R", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("entry kind on R", 32'(e.wr), 32'd0);
      check("rresp", 32'(s_axi_rresp), 32'(e.resp));
      check("rdata", s_axi_rdata, e.data);
    end
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
    check("rvalid after R hs", 32'(s_axi_rvalid), 32'd0);
    check("arready after R hs", 32'(s_axi_arready), 32'd1);
  endtask

  initial begin
    int base;
    //            wr    addr     data          strb   resp   rdata
    vecs[0]  = '{1'b1, 11'h010, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
    vecs[1]  = '{1'b0, 11'h010, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 11'h000, 32'hAABBCCDD, 4'hF, 2'b00, 32'h0};
    vecs[3]  = '{1'b1, 11'h100, 32'h12345678, 4'hF, 2'b10, 32'h0};
    vecs[4]  = '{1'b0, 11'h1FC, 32'h0,        4'h0, 2'b10, 32'h0};
    vecs[5]  = '{1'b0, 11'h000, 32'h0,        4'h0, 2'b00, 32'hAABBCCDD};
    vecs[6]  = '{1'b1, 11'h013, 32'h0000FFFF, 4'h3, 2'b00, 32'h0};
    vecs[7]  = '{1'b0, 11'h010, 32'h0,        4'h0, 2'b00, 32'hDEADFFFF};
    vecs[8]  = '{1'b1, 11'h014, 32'hFFFFFFFF, 4'h0, 2'b00, 32'h0};
    vecs[9]  = '{1'b0, 11'h014, 32'h0,        4'h0, 2'b00, 32'h0};
    vecs[10] = '{1'b0, 11'h0FC, 32'h0,        4'h0, 2'b00, 32'h0};
    vecs[11] = '{1'b1, 11'h0FC, 32'hCAFEF00D, 4'hF, 2'b00, 32'h0};
    vecs[12] = '{1'b0, 11'h0FC, 32'h0,        4'h0, 2'b00, 32'hCAFEF00D};
    vecs[13] = '{1'b0, 11'h100, 32'h0,        4'h0, 2'b10, 32'h0};

    axi_reset_n = 1'b0;
    s_axi_awvalid = 1'b0; s_axi_awaddr = '0;
    s_axi_wvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_bready = 1'b0;
    s_axi_arvalid = 1'b0; s_axi_araddr = '0;
    s_axi_rready = 1'b0;
    snap_index = '0;
    #12;
    check("reset awready", 32'(s_axi_awready), 32'd1);
    check("reset wready", 32'(s_axi_wready), 32'd1);
    check("reset arready", 32'(s_axi_arready), 32'd1);
    check("reset bvalid", 32'(s_axi_bvalid), 32'd0);
    check("reset rvalid", 32'(s_axi_rvalid), 32'd0);
    check("reset bresp", 32'(s_axi_bresp), 32'd0);
    check("reset rresp", 32'(s_axi_rresp), 32'd0);
    check("reset rdata", s_axi_rdata, 32'd0);
    check("reset pulse", 32'(reg_wr_pulse), 32'd0);
    check("reset wr_index", 32'(reg_wr_index), 32'd0);
    @(negedge axi_clk);
    axi_reset_n = 1'b1;
    tick();

    // Table-driven single transactions.
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) begin
        drive_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp);
        collect_write();
      end else begin
        drive_read(vecs[i].addr, vecs[i].resp, vecs[i].rdata);
        collect_read();
      end
    end
    snap_index = 6'd0;  #1 check("snap reg0 after SLVERR write", snap_data, 32'hAABBCCDD);
    snap_index = 6'd63; #1 check("snap reg63", snap_data, 32'hCAFEF00D);

    // W leads AW by 3 cycles, partial strobes onto 0xAABBCCDD.
    base = pulse_cnt;
    s_axi_wdata = 32'h11223344; s_axi_wstrb = 4'b0101; s_axi_wvalid = 1'b1;
    tick();
    s_axi_wvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("W-first wready low", 32'(s_axi_wready), 32'd0);
      check("W-first bvalid low", 32'(s_axi_bvalid), 32'd0);
      tick();
    end
    check("W-first awready high", 32'(s_axi_awready), 32'd1);
    s_axi_awaddr = 11'h000; s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    check("W-first bvalid", 32'(s_axi_bvalid), 32'd1);
    check("W-first bresp", 32'(s_axi_bresp), 32'd0);
    check("W-first pulse", 32'(reg_wr_pulse), 32'd1);
    check("W-first index", 32'(reg_wr_index), 32'd0);
    check("W-first wready in resp", 32'(s_axi_wready), 32'd0);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    check("W-first wready restored", 32'(s_axi_wready), 32'd1);
    snap_index = 6'd0; #1 check("W-first snap", snap_data, 32'hAA22CC44);
    check("W-first pulse count", 32'(pulse_cnt - base), 32'd1);
    drive_read(11'h000, 2'b00, 32'hAA22CC44);
    collect_read();

    // bready held low: B stable, next AW blocked until the B handshake.
    base = pulse_cnt;
    drive_write(11'h020, 32'h00000077, 4'hF, 2'b00);
    void'(sb.pop_front());
    s_axi_awaddr = 11'h024; s_axi_awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("hold bvalid", 32'(s_axi_bvalid), 32'd1);
      check("hold bresp", 32'(s_axi_bresp), 32'd0);
      check("hold awready", 32'(s_axi_awready), 32'd0);
      tick();
    end
    check("hold pulse count", 32'(pulse_cnt - base), 32'd1);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    check("post-hold awready", 32'(s_axi_awready), 32'd1);
    check("post-hold bvalid", 32'(s_axi_bvalid), 32'd0);
    tick();
    s_axi_awvalid = 1'b0;
    check("queued AW accepted", 32'(s_axi_awready), 32'd0);
    check("queued AW no bvalid yet", 32'(s_axi_bvalid), 32'd0);
    s_axi_wdata = 32'h00000088; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    tick();
    s_axi_wvalid = 1'b0;
    check("queued AW bvalid", 32'(s_axi_bvalid), 32'd1);
    check("queued AW index", 32'(reg_wr_index), 32'd9);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    drive_read(11'h024, 2'b00, 32'h00000088);
    collect_read();
    drive_read(11'h020, 2'b00, 32'h00000077);
    collect_read();

    // Same-cycle read and write of index 7: read sees the old value.
    drive_write(11'h01C, 32'h5, 4'hF, 2'b00);
    collect_write();
    s_axi_awaddr = 11'h01C; s_axi_wdata = 32'h9; s_axi_wstrb = 4'hF;
    s_axi_araddr = 11'h01C;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    check("collide rvalid", 32'(s_axi_rvalid), 32'd1);
    check("collide rdata old", s_axi_rdata, 32'h5);
    check("collide bvalid", 32'(s_axi_bvalid), 32'd1);
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    tick();
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    drive_read(11'h01C, 2'b00, 32'h9);
    collect_read();

    // Reset while holding only an AW.
    base = pulse_cnt;
    s_axi_awaddr = 11'h010; s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    check("have_aw awready low", 32'(s_axi_awready), 32'd0);
    #2 axi_reset_n = 1'b0;
    #1;
    check("mid-reset awready", 32'(s_axi_awready), 32'd1);
    check("mid-reset wready", 32'(s_axi_wready), 32'd1);
    check("mid-reset arready", 32'(s_axi_arready), 32'd1);
    check("mid-reset bvalid", 32'(s_axi_bvalid), 32'd0);
    check("mid-reset pulse", 32'(reg_wr_pulse), 32'd0);
    snap_index = 6'd4; #1 check("mid-reset reg4", snap_data, 32'h0);
    snap_index = 6'd7; #1 check("mid-reset reg7", snap_data, 32'h0);
    @(negedge axi_clk);
    axi_reset_n = 1'b1;
    tick();
    s_axi_wdata = 32'h12345678; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    tick();
    s_axi_wvalid = 1'b0;
    check("stale AW discarded", 32'(s_axi_bvalid), 32'd0);
    check("W-only wready low", 32'(s_axi_wready), 32'd0);
    tick();
    check("no pulse after reset", 32'(pulse_cnt - base), 32'd0);
    snap_index = 6'd4; #1 check("reg4 untouched", snap_data, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
